// File: rtl/mul_sched_pkg.sv
// Shared definitions for the shared multiplier scheduler.
//   req_id_t : identifies which requester an operation belongs to
//   DEF_N    : default operand width
//   DEF_LAT  : default multiplier pipeline depth
package mul_sched_pkg;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_t;

    localparam int DEF_N   = 8;
    localparam int DEF_LAT = 2;

endpackage

// File: rtl/shared_mul_scheduler_if.sv
// Handshake/result bundle between two requesters and the scheduler.
//   req*_vld/rdy      : request handshake per requester
//   req*_a/b/signed   : operands and signedness per requester
//   res*_vld/data     : one-cycle result strobe and product per requester
//   busy              : any operation in flight
// Modports: master = requester side, slave = scheduler side.
interface shared_mul_scheduler_if #(
    parameter int n = 8
);
    logic           req0_vld;
    logic           req1_vld;
    logic           req0_rdy;
    logic           req1_rdy;
    logic [n-1:0]   req0_a;
    logic [n-1:0]   req0_b;
    logic [n-1:0]   req1_a;
    logic [n-1:0]   req1_b;
    logic           req0_signed;
    logic           req1_signed;
    logic           res0_vld;
    logic           res1_vld;
    logic [2*n-1:0] res0_data;
    logic [2*n-1:0] res1_data;
    logic           busy;

    modport master (
        output req0_vld, req1_vld, req0_a, req0_b, req1_a, req1_b,
               req0_signed, req1_signed,
        input  req0_rdy, req1_rdy, res0_vld, res1_vld, res0_data, res1_data,
               busy
    );

    modport slave (
        input  req0_vld, req1_vld, req0_a, req0_b, req1_a, req1_b,
               req0_signed, req1_signed,
        output req0_rdy, req1_rdy, res0_vld, res1_vld, res0_data, res1_data,
               busy
    );
endinterface

// File: rtl/mul_pipe.sv
// Signed/unsigned multiply pipeline of lat stages carrying valid and id.
//   in_*     : operation entering stage 0 on the next rising edge
//   out_vld  : last stage holds a valid operation
//   out_id   : requester id of the last stage
//   out_prod : 2*n-bit product of the last stage's operands
//   busy     : OR of all stage valid bits
module mul_pipe
    import mul_sched_pkg::*;
#(
    parameter int n   = DEF_N,
    parameter int lat = DEF_LAT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_vld,
    input  req_id_t        in_id,
    input  logic [n-1:0]   in_a,
    input  logic [n-1:0]   in_b,
    input  logic           in_signed,
    output logic           out_vld,
    output req_id_t        out_id,
    output logic [2*n-1:0] out_prod,
    output logic           busy
);

    typedef struct packed {
        logic         vld;
        req_id_t      id;
        logic         sgn;
        logic [n-1:0] a;
        logic [n-1:0] b;
    } stage_t;

    stage_t stage_reg [lat];
    stage_t in_stage;

    assign in_stage = '{vld: in_vld, id: in_id, sgn: in_signed, a: in_a, b: in_b};

    genvar gi;
    generate
        for (gi = 0; gi < lat; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        stage_reg[0] <= '0;
                    end else begin
                        stage_reg[0] <= in_stage;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        stage_reg[gi] <= '0;
                    end else begin
                        stage_reg[gi] <= stage_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < lat; i++) begin
            busy = busy | stage_reg[i].vld;
        end
    end

    // Extending to 2*n bits before multiplying makes a single 2*n x 2*n
    // multiply (truncated to 2*n) exact for both signed and unsigned operands.
    logic [2*n-1:0] a_ext;
    logic [2*n-1:0] b_ext;

    always_comb begin
        a_ext = stage_reg[lat-1].sgn ? {{n{stage_reg[lat-1].a[n-1]}}, stage_reg[lat-1].a}
                                     : {{n{1'b0}}, stage_reg[lat-1].a};
        b_ext = stage_reg[lat-1].sgn ? {{n{stage_reg[lat-1].b[n-1]}}, stage_reg[lat-1].b}
                                     : {{n{1'b0}}, stage_reg[lat-1].b};
    end

    assign out_prod = a_ext * b_ext;
    assign out_vld  = stage_reg[lat-1].vld;
    assign out_id   = stage_reg[lat-1].id;

endmodule

// File: rtl/shared_mul_scheduler.sv
// Two requesters sharing one pipelined multiplier.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of shared_mul_scheduler_if (requests, results, busy)
// Round-robin arbitration between simultaneous requests, one accept per
// cycle, results demultiplexed to the owning requester lat cycles after
// the accepting edge.
module shared_mul_scheduler
    import mul_sched_pkg::*;
#(
    parameter int n   = DEF_N,
    parameter int lat = DEF_LAT
) (
    input  logic                   clk,
    input  logic                   rst,
    shared_mul_scheduler_if.slave  bus
);

    req_id_t        last_reg;      // requester granted at the most recent accept
    req_id_t        grant_id;
    logic           accept;
    logic [n-1:0]   pipe_a;
    logic [n-1:0]   pipe_b;
    logic           pipe_signed;
    logic           pipe_out_vld;
    req_id_t        pipe_out_id;
    logic [2*n-1:0] pipe_out_prod;
    logic           pipe_busy;

    logic           res0_vld_reg;
    logic           res1_vld_reg;
    logic [2*n-1:0] res0_data_reg;
    logic [2*n-1:0] res1_data_reg;

    // A lone requester always wins; under contention the one not granted
    // last time wins. Reset leaves last_reg = REQ1 so REQ0 wins first.
    always_comb begin
        if (bus.req0_vld && !bus.req1_vld) begin
            grant_id = REQ0;
        end else if (bus.req1_vld && !bus.req0_vld) begin
            grant_id = REQ1;
        end else begin
            grant_id = (last_reg == REQ0) ? REQ1 : REQ0;
        end
    end

    assign accept       = !rst && (bus.req0_vld || bus.req1_vld);
    assign bus.req0_rdy = accept && (grant_id == REQ0);
    assign bus.req1_rdy = accept && (grant_id == REQ1);

    assign pipe_a      = (grant_id == REQ1) ? bus.req1_a      : bus.req0_a;
    assign pipe_b      = (grant_id == REQ1) ? bus.req1_b      : bus.req0_b;
    assign pipe_signed = (grant_id == REQ1) ? bus.req1_signed : bus.req0_signed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_reg <= REQ1;
        end else if (accept) begin
            last_reg <= grant_id;
        end
    end

    mul_pipe #(
        .n   (n),
        .lat (lat)
    ) u_mul_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (accept),
        .in_id     (grant_id),
        .in_a      (pipe_a),
        .in_b      (pipe_b),
        .in_signed (pipe_signed),
        .out_vld   (pipe_out_vld),
        .out_id    (pipe_out_id),
        .out_prod  (pipe_out_prod),
        .busy      (pipe_busy)
    );

    // Registered result demux: data is forced to zero on the idle port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res0_vld_reg  <= 1'b0;
            res1_vld_reg  <= 1'b0;
            res0_data_reg <= '0;
            res1_data_reg <= '0;
        end else begin
            res0_vld_reg  <= pipe_out_vld && (pipe_out_id == REQ0);
            res1_vld_reg  <= pipe_out_vld && (pipe_out_id == REQ1);
            res0_data_reg <= (pipe_out_vld && (pipe_out_id == REQ0)) ? pipe_out_prod : '0;
            res1_data_reg <= (pipe_out_vld && (pipe_out_id == REQ1)) ? pipe_out_prod : '0;
        end
    end

    assign bus.res0_vld  = res0_vld_reg;
    assign bus.res1_vld  = res1_vld_reg;
    assign bus.res0_data = res0_data_reg;
    assign bus.res1_data = res1_data_reg;
    assign bus.busy      = pipe_busy;

endmodule

// File: tb/tb_shared_mul_scheduler.sv
// Self-checking bench for shared_mul_scheduler (n=8, lat=2).
module tb_shared_mul_scheduler;
    import mul_sched_pkg::*;

    localparam int N   = 8;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    shared_mul_scheduler_if #(.n(N)) bus();

    shared_mul_scheduler #(.n(N), .lat(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit last_one;        // model: 1 when requester 1 won the last accept
    int last_grant;

    typedef struct {
        int          due;
        bit          id;
        logic [15:0] prod;
    } exp_t;
    exp_t pend[$];

    logic        obs_v0, obs_v1;
    logic [15:0] obs_d0, obs_d1;

    typedef struct {
        bit          req;
        logic [7:0]  a;
        logic [7:0]  b;
        bit          sgn;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl [5];

    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input bit s);
        longint x, y;
        x = s ? longint'($signed(a)) : longint'(a);
        y = s ? longint'($signed(b)) : longint'(b);
        return 16'(x * y);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check ready, clock, check results.
    task automatic cycle(input bit v0, input logic [7:0] a0, input logic [7:0] b0, input bit s0,
                         input bit v1, input logic [7:0] a1, input logic [7:0] b1, input bit s1);
        bit          g0, g1, ev0, ev1;
        logic [15:0] ed0, ed1;
        exp_t        e;
        bus.req0_vld = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_signed = s0;
        bus.req1_vld = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_signed = s1;
        #1;
        g0 = v0 && (!v1 || last_one);
        g1 = v1 && (!v0 || !last_one);
        chk("req0_rdy", 32'(bus.req0_rdy), 32'(g0));
        chk("req1_rdy", 32'(bus.req1_rdy), 32'(g1));
        last_grant = -1;
        if (g0 || g1) begin
            e.due  = cyc + 1 + LAT;
            e.id   = g1;
            e.prod = g1 ? ref_mul(a1, b1, s1) : ref_mul(a0, b0, s0);
            pend.push_back(e);
            last_one   = g1;
            last_grant = g1 ? 1 : 0;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        ev0 = 0; ev1 = 0; ed0 = '0; ed1 = '0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            e = pend.pop_front();
            if (e.id) begin ev1 = 1; ed1 = e.prod; end
            else      begin ev0 = 1; ed0 = e.prod; end
        end
        obs_v0 = bus.res0_vld; obs_v1 = bus.res1_vld;
        obs_d0 = bus.res0_data; obs_d1 = bus.res1_data;
        chk("res0_vld",  32'(obs_v0), 32'(ev0));
        chk("res1_vld",  32'(obs_v1), 32'(ev1));
        chk("res0_data", 32'(obs_d0), 32'(ed0));
        chk("res1_data", 32'(obs_d1), 32'(ed1));
        chk("busy",      32'(bus.busy), 32'(pend.size() > 0));
        $display("cyc=%0d v=%0d%0d grant=%0d res0=%0d/%h res1=%0d/%h busy=%0d",
                 cyc, v0, v1, last_grant, obs_v0, obs_d0, obs_v1, obs_d1, bus.busy);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cycle(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    endtask

    // Called at a negedge; reset must act without waiting for a clock edge.
    task automatic do_reset();
        rst = 1'b1;
        pend.delete();
        last_one = 1;
        bus.req0_vld = 1'b1;
        bus.req1_vld = 1'b1;
        #1;
        chk("rst_req0_rdy", 32'(bus.req0_rdy), 32'd0);
        chk("rst_req1_rdy", 32'(bus.req1_rdy), 32'd0);
        chk("rst_busy",     32'(bus.busy),     32'd0);
        chk("rst_res_vld",  32'({bus.res0_vld, bus.res1_vld}), 32'd0);
        chk("rst_res_data", {bus.res0_data, bus.res1_data}, 32'd0);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1'b0;
        $display("cyc=%0d reset released", cyc);
    endtask

    initial begin
        rst = 1'b1;
        bus.req0_vld = 0; bus.req1_vld = 0;
        bus.req0_a = '0; bus.req0_b = '0; bus.req1_a = '0; bus.req1_b = '0;
        bus.req0_signed = 0; bus.req1_signed = 0;
        last_one = 1;

        tbl[0] = '{req: 0, a: 8'hFF, b: 8'h02, sgn: 1, exp: 16'hFFFE};
        tbl[1] = '{req: 0, a: 8'hFF, b: 8'h02, sgn: 0, exp: 16'h01FE};
        tbl[2] = '{req: 1, a: 8'h80, b: 8'h7F, sgn: 1, exp: 16'hC080};
        tbl[3] = '{req: 0, a: 8'h80, b: 8'h7F, sgn: 0, exp: 16'h3F80};
        tbl[4] = '{req: 1, a: 8'h80, b: 8'h80, sgn: 1, exp: 16'h4000};

        @(negedge clk);
        do_reset();

        // Directed single requests with constant expected products.
        for (int i = 0; i < 5; i++) begin
            if (tbl[i].req) cycle(0, 8'h00, 8'h00, 0, 1, tbl[i].a, tbl[i].b, tbl[i].sgn);
            else            cycle(1, tbl[i].a, tbl[i].b, tbl[i].sgn, 0, 8'h00, 8'h00, 0);
            idle(LAT);
            chk("tbl_vld",  32'(tbl[i].req ? obs_v1 : obs_v0), 32'd1);
            chk("tbl_data", 32'(tbl[i].req ? obs_d1 : obs_d0), 32'(tbl[i].exp));
        end

        // Contention right after reset: grants must alternate 0,1,0,1.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1, 8'($urandom), 8'($urandom), bit'($urandom_range(0, 1)),
                  1, 8'($urandom), 8'($urandom), bit'($urandom_range(0, 1)));
            chk("contend_grant", 32'(last_grant), 32'(i % 2));
        end
        idle(LAT);

        // Back-to-back single requester.
        for (int i = 0; i < 5; i++) begin
            cycle(0, 8'h00, 8'h00, 0, 1, 8'($urandom), 8'($urandom), bit'($urandom_range(0, 1)));
            chk("b2b_busy", 32'(bus.busy), 32'd1);
        end
        idle(LAT);

        // Reset one cycle after an accept: the operation must vanish.
        cycle(1, 8'h12, 8'h34, 0, 0, 8'h00, 8'h00, 0);
        idle(1);
        do_reset();
        idle(LAT + 1);

        // Pointer holds across idle cycles.
        cycle(1, 8'h03, 8'h05, 0, 0, 8'h00, 8'h00, 0);
        idle(3);
        cycle(1, 8'h07, 8'h09, 0, 1, 8'h0B, 8'h0D, 1);
        chk("hold_grant", 32'(last_grant), 32'd1);
        idle(LAT);

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            cycle(bit'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), bit'($urandom_range(0, 1)),
                  bit'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), bit'($urandom_range(0, 1)));
        end
        idle(LAT + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
